// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response, decode-side head port.
// The master modport is the fetch queue itself; the slave modport is the memory/decode environment.
interface fetch_queue_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
);
   logic                     redirect;
   logic [ADDRESS_WIDTH-1:0] redirect_pc;
   logic                     imem_req;
   logic [ADDRESS_WIDTH-1:0] imem_addr;
   logic                     imem_gnt;
   logic                     imem_rvalid;
   logic [DATA_WIDTH-1:0]    imem_rdata;
   logic                     instr_valid;
   logic [DATA_WIDTH-1:0]    instr;
   logic [ADDRESS_WIDTH-1:0] instr_pc;
   logic                     instr_ready;

   modport master (
      input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
      output imem_req, imem_addr, instr_valid, instr, instr_pc
   );

   modport slave (
      output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order memory requests and buffers responses with their PCs.
// Grant-to-head latency is 2 cycles with 1-cycle memory; requests stall while queue + in-flight reaches DEPTH.
module fetch_queue #(
   parameter int                       ADDRESS_WIDTH = 8,
   parameter int                       DATA_WIDTH    = 32,
   parameter int                       DEPTH         = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {FETCH, FLUSH} state_t;

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] fetch_pc;
   logic [CW-1:0]            q_cnt, out_cnt, stale_cnt, out_nxt, stale_nxt;
   logic [PW-1:0]            rd_ptr, wr_ptr, if_rd, if_wr;
   logic [DATA_WIDTH-1:0]    q_dat [DEPTH];
   logic [ADDRESS_WIDTH-1:0] q_pc  [DEPTH];
   logic [ADDRESS_WIDTH-1:0] if_pc [DEPTH];
   logic                     req, gnt, rvalid, push, pop;

   always_comb begin
      req     = !rst && (state == FETCH) && !bus.redirect &&
                (({1'b0, q_cnt} + {1'b0, out_cnt}) < (CW + 1)'(DEPTH));
      gnt     = req && bus.imem_gnt;
      rvalid  = bus.imem_rvalid;
      out_nxt = out_cnt + CW'(gnt) - CW'(rvalid);
      push    = (state == FETCH) && !bus.redirect && rvalid;
      pop     = (q_cnt != '0) && bus.instr_ready && !bus.redirect;
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr_valid = (q_cnt != '0);
   assign bus.instr       = q_dat[rd_ptr];
   assign bus.instr_pc    = q_pc[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         stale_cnt <= '0;
      end else begin
         state     <= state_nxt;
         stale_cnt <= stale_nxt;
      end
   end

   // Stale count tracks responses still owed for requests issued before the last redirect.
   always_comb begin
      state_nxt = state;
      stale_nxt = stale_cnt;
      if (bus.redirect) begin
         stale_nxt = out_nxt;
         state_nxt = (out_nxt != '0) ? FLUSH : FETCH;
      end else if ((state == FLUSH) && rvalid) begin
         stale_nxt = stale_cnt - CW'(1);
         if (stale_cnt == CW'(1)) state_nxt = FETCH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         out_cnt  <= '0;
         q_cnt    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         if_rd    <= '0;
         if_wr    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_dat[i] <= '0;
            q_pc[i]  <= '0;
            if_pc[i] <= '0;
         end
      end else begin
         out_cnt <= out_nxt;
         // In-flight PC FIFO advances on every grant/response, stale or not, to stay aligned with memory.
         if (gnt) begin
            if_pc[if_wr] <= fetch_pc;
            if_wr        <= if_wr + PW'(1);
         end
         if (rvalid) if_rd <= if_rd + PW'(1);

         if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc & ~ADDRESS_WIDTH'(3);
            q_cnt    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (gnt) fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
            if (push) begin
               q_dat[wr_ptr] <= bus.imem_rdata;
               q_pc[wr_ptr]  <= if_pc[if_rd];
               wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            q_cnt <= q_cnt + CW'(push) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a memory responder with in-order variable latency and a
// reference model built from request/response tags and a plain queue of expected head PCs.
module tb_fetch_queue;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_queue_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   fetch_queue #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .RESET_PC     (8'h00)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      int            t;
      bit            stale;
   } fl_t;

   fl_t           fl[$];
   logic [AW-1:0] mq[$];
   logic [AW-1:0] m_pc;
   int            cyc;
   int            n_vec;
   int            n_err;

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return {8'hC3, ~a, a ^ 8'h5A, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit flushing();
      foreach (fl[i]) if (fl[i].stale) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive_idle();
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.instr_ready = 1'b0;
   endtask

   task automatic model_reset();
      fl.delete();
      mq.delete();
      m_pc = 8'h00;
   endtask

   // Called at a falling edge; leaves at the next falling edge.
   task automatic step(input bit redir, input logic [AW-1:0] rpc, input bit gnt,
                       input bit rdy, input int lat, input bit rv_en);
      bit  rv, exp_req, do_pop;
      fl_t e;
      rv = rv_en && (fl.size() > 0);
      if (rv) rv = (fl[0].t <= cyc);
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      bus.imem_gnt    = gnt;
      bus.instr_ready = rdy;
      bus.imem_rvalid = rv;
      if (rv) bus.imem_rdata = memf(fl[0].a);
      else    bus.imem_rdata = DW'($urandom);
      #1;
      exp_req = !redir && !flushing() && ((mq.size() + fl.size()) < DEPTH);
      chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
      chk("instr_valid", 64'(bus.instr_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("instr_pc", 64'(bus.instr_pc), 64'(mq[0]));
         chk("instr", 64'(bus.instr), 64'(memf(mq[0])));
      end
      do_pop = !redir && rdy && (mq.size() != 0);
      @(posedge clk);
      if (do_pop) void'(mq.pop_front());
      if (rv) begin
         e = fl.pop_front();
         if (!e.stale && !redir) mq.push_back(e.a);
      end
      if (exp_req && gnt) begin
         fl.push_back('{a: m_pc, t: cyc + 1 + lat, stale: 1'b0});
         m_pc = m_pc + 8'd4;
      end
      if (redir) begin
         mq.delete();
         foreach (fl[i]) fl[i].stale = 1'b1;
         m_pc = rpc & ~8'h03;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      #1;
      chk("rst_req", 64'(bus.imem_req), 64'd0);
      chk("rst_valid", 64'(bus.instr_valid), 64'd0);
      chk("rst_instr", 64'(bus.instr), 64'd0);
      chk("rst_pc", 64'(bus.instr_pc), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      drive_idle();
      model_reset();
      @(negedge clk);
      do_reset();

      // Full-rate streaming from reset.
      stream(20);

      // Decode stalled: queue fills to DEPTH, requests stop, then drain in order.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1);
      stream(12);

      // Redirect with slow responses outstanding; unaligned target.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1);
      step(1'b1, 8'h43, 1'b1, 1'b1, 0, 1'b1);
      stream(15);

      // Redirect coinciding with response and pop.
      stream(6);
      step(1'b1, 8'h80, 1'b1, 1'b1, 0, 1'b1);
      stream(8);

      // Address wrap past the top of the space.
      step(1'b1, 8'hF8, 1'b1, 1'b1, 0, 1'b1);
      stream(10);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) < 3, AW'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0);

      // Asynchronous reset between clock edges during streaming.
      stream(5);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_req", 64'(bus.imem_req), 64'd0);
      chk("async_rst_valid", 64'(bus.instr_valid), 64'd0);
      drive_idle();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      stream(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
